// File: rtl/conv_stream_ctrl_pkg.sv
// conv_stream_ctrl_pkg
//   Shared definitions for the conv block and its host-side driver:
//   word widths, register-file depths, the driver FSM state encoding and
//   the default result_done timeout.
package conv_stream_ctrl_pkg;

    // Existing conv block definitions
    localparam int PATTERN_BIT = 7;
    localparam int KERNEL_BIT  = 7;
    localparam int RESULT_BIT  = 15;
    localparam int PATTERN_NUM = 9;
    localparam int KERNEL_NUM  = 4;
    localparam int RESULT_NUM  = 4;

    // Cycles spent in WAIT without result_done before giving up
    localparam int TIMEOUT_DEF = 16;

    // Driver FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_FEED = 3'd2,
        ST_WAIT = 3'd3,
        ST_CAPT = 3'd4
    } conv_state_t;

endpackage

// File: rtl/conv_stream_ctrl.sv
// conv_stream_ctrl
//   Host-side driver for the conv block. Holds one 3x3 pattern and one 2x2
//   kernel written by the host, and on start streams them into conv (one word
//   per cycle), then captures the four serial results qualified by
//   result_done into a result file the host reads back.
//
// Ports
//   Aclk, rst            clock, asynchronous active-high reset
//   wr_en/wr_sel/wr_addr/wr_data
//                        host write port (wr_sel 0 = pattern 0..8,
//                        1 = kernel 0..3); ignored while busy
//   start                run request, honoured only when idle
//   rd_addr/rd_data      combinational read of the result file
//   busy/done/err        run status; done is a one-cycle pulse, err is sticky
//                        until the next accepted start
//   conv_rst/conv_xin/conv_kin/conv_rout/conv_result_done
//                        interface to the conv block
//
// Handshake: start is a level sampled only in IDLE; it needs no ready, the
// host watches busy (high from the accepted start until the edge that
// raises done) and done (one-cycle pulse marking the end of a run, normal
// or error). Results in the file are valid whenever busy is low.
module conv_stream_ctrl
    import conv_stream_ctrl_pkg::*;
#(
    parameter int PAT_W   = PATTERN_BIT + 1,
    parameter int KER_W   = KERNEL_BIT + 1,
    parameter int RES_W   = RESULT_BIT + 1,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             Aclk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [3:0]       wr_addr,
    input  logic [PAT_W-1:0] wr_data,
    input  logic             start,
    input  logic [1:0]       rd_addr,
    output logic [RES_W-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             conv_rst,
    output logic [PAT_W-1:0] conv_xin,
    output logic [KER_W-1:0] conv_kin,
    input  logic [RES_W-1:0] conv_rout,
    input  logic             conv_result_done
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [PAT_W-1:0] pat_mem [PATTERN_NUM];
    logic [KER_W-1:0] ker_mem [KERNEL_NUM];
    logic [RES_W-1:0] res_mem [RESULT_NUM];

    conv_state_t      state;
    logic [3:0]       idx;
    logic [1:0]       cap_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    assign rd_data = res_mem[rd_addr];

    // Host register files. The write port is locked out for the whole run so
    // the words streamed to conv cannot change underneath it.
    always_ff @(posedge Aclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PATTERN_NUM; i++) pat_mem[i] <= '0;
            for (int i = 0; i < KERNEL_NUM; i++)  ker_mem[i] <= '0;
        end else if (wr_en && !busy) begin
            if (!wr_sel) begin
                if (wr_addr <= 4'd8) pat_mem[wr_addr] <= wr_data;
            end else begin
                if (wr_addr <= 4'd3) ker_mem[wr_addr[1:0]] <= wr_data[KER_W-1:0];
            end
        end
    end

    // Run sequencer. All conv-facing outputs and status flags are registered
    // here; done defaults low so it only ever pulses for one cycle.
    always_ff @(posedge Aclk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            conv_rst <= 1'b1;
            conv_xin <= '0;
            conv_kin <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            idx      <= '0;
            cap_cnt  <= '0;
            tmo_cnt  <= '0;
            for (int i = 0; i < RESULT_NUM; i++) res_mem[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    conv_rst <= 1'b1;
                    conv_xin <= '0;
                    conv_kin <= '0;
                    if (start) begin
                        state <= ST_ARM;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                    end
                end

                // Release conv and present word 0 in the same cycle so conv
                // sees its first operands on the first edge out of reset.
                ST_ARM: begin
                    conv_rst <= 1'b0;
                    conv_xin <= pat_mem[0];
                    conv_kin <= ker_mem[0];
                    idx      <= 4'd1;
                    state    <= ST_FEED;
                end

                ST_FEED: begin
                    conv_xin <= pat_mem[idx];
                    conv_kin <= (idx <= 4'd3) ? ker_mem[idx[1:0]] : '0;
                    idx      <= idx + 4'd1;
                    if (idx == 4'd8) begin
                        state   <= ST_WAIT;
                        tmo_cnt <= '0;
                    end
                end

                ST_WAIT: begin
                    conv_xin <= '0;
                    conv_kin <= '0;
                    if (conv_result_done) begin
                        res_mem[0] <= conv_rout;
                        cap_cnt    <= 2'd1;
                        state      <= ST_CAPT;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        err      <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        conv_rst <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                // result_done must stay high for all four results; a drop
                // ends the run as an error without sampling that cycle.
                ST_CAPT: begin
                    if (!conv_result_done) begin
                        err      <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        conv_rst <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        res_mem[cap_cnt] <= conv_rout;
                        cap_cnt          <= cap_cnt + 2'd1;
                        if (cap_cnt == 2'd3) begin
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            conv_rst <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    conv_rst <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
module tb_conv_stream_ctrl;
    import conv_stream_ctrl_pkg::*;

    localparam int PW = PATTERN_BIT + 1;
    localparam int KW = KERNEL_BIT + 1;
    localparam int RW = RESULT_BIT + 1;

    // ---------------- clock / reset ----------------
    logic          Aclk = 1'b0;
    logic          rst  = 1'b1;
    logic          wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
    logic [3:0]    wr_addr = '0;
    logic [PW-1:0] wr_data = '0;
    logic [1:0]    rd_addr = '0;
    logic [RW-1:0] rd_data;
    logic          busy, done, err, conv_rst;
    logic [PW-1:0] conv_xin;
    logic [KW-1:0] conv_kin;
    logic [RW-1:0] conv_rout;
    logic          conv_result_done;

    always #5 Aclk = ~Aclk;

    conv_stream_ctrl dut (
        .Aclk(Aclk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .conv_rst(conv_rst), .conv_xin(conv_xin), .conv_kin(conv_kin),
        .conv_rout(conv_rout), .conv_result_done(conv_result_done)
    );

    // ---------------- behavioural conv block ----------------
    // Samples Xin/Kin from the first edge after reset release, raises
    // result_done after the ninth pattern word and streams 4 results, then
    // keeps result_done high with a junk value that must never be captured.
    bit            tie_low   = 1'b0;
    bit            drop_mode = 1'b0;
    int            mcnt;
    logic [PW-1:0] px [9];
    logic [KW-1:0] kx [4];

    function automatic logic [RW-1:0] conv_calc(input int i);
        int r, c, s;
        r = i / 2; c = i % 2; s = 0;
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                s += int'(px[(r + a) * 3 + c + b]) * int'(kx[a * 2 + b]);
        return RW'(s);
    endfunction

    always @(posedge Aclk) begin
        if (conv_rst) begin
            mcnt             <= 0;
            conv_result_done <= 1'b0;
            conv_rout        <= '0;
        end else begin
            if (mcnt < 9) px[mcnt] <= conv_xin;
            if (mcnt < 4) kx[mcnt] <= conv_kin;
            if (mcnt < 60) mcnt <= mcnt + 1;
            if (mcnt >= 9 && mcnt <= 12) begin
                conv_rout        <= conv_calc(mcnt - 9);
                conv_result_done <= !tie_low && !(drop_mode && mcnt == 11);
            end else if (mcnt > 12) begin
                conv_rout        <= 16'hDEAD;
                conv_result_done <= !tie_low;
            end else begin
                conv_result_done <= 1'b0;
            end
        end
    end

    // ---------------- vectors / scoreboard ----------------
    typedef struct {
        logic [PW-1:0] p [9];
        logic [KW-1:0] k [4];
        logic [RW-1:0] r [4];
    } vec_t;

    vec_t          vecs [5];
    logic [RW-1:0] exp_q [$];
    logic [PW-1:0] cur_p [9];
    logic [KW-1:0] cur_k [4];
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_word(input logic sel, input logic [3:0] addr, input logic [PW-1:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        @(negedge Aclk);
        wr_en = 1'b0;
    endtask

    task automatic load(input int vi);
        for (int i = 0; i < 9; i++) begin
            write_word(1'b0, 4'(i), vecs[vi].p[i]);
            cur_p[i] = vecs[vi].p[i];
        end
        for (int i = 0; i < 4; i++) begin
            write_word(1'b1, 4'(i), PW'(vecs[vi].k[i]));
            cur_k[i] = vecs[vi].k[i];
        end
    endtask

    task automatic push_exp(input int vi);
        for (int i = 0; i < 4; i++) exp_q.push_back(vecs[vi].r[i]);
    endtask

    // Runs one start from a negedge. edges counts posedges since start was
    // driven, so done seen with edges==N means done rose N cycles after start.
    task automatic run(input string tag, input int exp_edges, input bit seq_chk,
                       input bit mess, input bit abort5, input bit exp_err);
        int  edges;
        bit  got, stop;
        logic [PW-1:0] ex;
        logic [KW-1:0] ek;
        start = 1'b1;
        @(negedge Aclk);
        start = 1'b0;
        edges = 1; got = 1'b0; stop = 1'b0;
        chk({tag, "_busy_at_start"}, busy, 1);
        chk({tag, "_err_cleared_at_start"}, err, 0);
        while (!got && !stop && edges < 80) begin
            if (seq_chk && edges <= 12) begin
                ex = (edges >= 2 && edges <= 10) ? cur_p[edges - 2] : '0;
                ek = (edges >= 2 && edges <= 5)  ? cur_k[edges - 2] : '0;
                chk($sformatf("%s_xin_S%0d", tag, edges - 1), conv_xin, ex);
                chk($sformatf("%s_kin_S%0d", tag, edges - 1), conv_kin, ek);
            end
            if (mess && edges == 3) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'hFF;
            end
            if (mess && edges == 4) begin
                wr_sel = 1'b1; start = 1'b1;
            end
            if (mess && edges == 5) begin
                wr_en = 1'b0; start = 1'b0;
            end
            if (abort5 && edges == 6) begin
                rst = 1'b1;
                #1;
                chk({tag, "_rst_conv_rst"}, conv_rst, 1);
                chk({tag, "_rst_busy"}, busy, 0);
                chk({tag, "_rst_xin"}, conv_xin, 0);
                chk({tag, "_rst_result0"}, rd_data, 0);
                @(negedge Aclk);
                rst = 1'b0;
                stop = 1'b1;
            end else if (done) begin
                got = 1'b1;
            end
            if (!got && !stop) begin
                @(negedge Aclk);
                edges++;
            end
        end
        if (stop) return;
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s_done_wait actual=no_done required=done_within_80", tag);
            return;
        end
        chk({tag, "_done_latency"}, edges, exp_edges);
        chk({tag, "_err"}, err, 32'(exp_err));
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_conv_rst_at_done"}, conv_rst, 1);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL %s_scoreboard_empty actual=0 required=4", tag);
            end else begin
                chk($sformatf("%s_result%0d", tag, i), rd_data, 32'(exp_q.pop_front()));
            end
        end
        @(negedge Aclk);
        chk({tag, "_done_one_cycle"}, done, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0].p = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        vecs[0].k = '{1, 0, 0, 1};
        vecs[0].r = '{6, 8, 12, 14};
        vecs[1].p = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        vecs[1].k = '{1, 1, 1, 1};
        vecs[1].r = '{4, 4, 4, 4};
        vecs[2].p = '{2, 0, 1, 3, 1, 0, 0, 4, 5};
        vecs[2].k = '{0, 1, 2, 0};
        vecs[2].r = '{6, 3, 1, 8};
        vecs[3].p = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        vecs[3].k = '{1, 1, 1, 1};
        vecs[3].r = '{28, 24, 16, 12};
        vecs[4].p = '{3, 1, 4, 1, 5, 9, 2, 6, 5};
        vecs[4].k = '{2, 7, 1, 8};
        vecs[4].r = '{54, 107, 87, 119};

        repeat (3) @(negedge Aclk);
        chk("reset_conv_rst", conv_rst, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_xin", conv_xin, 0);
        chk("reset_kin", conv_kin, 0);
        rst = 1'b0;
        @(negedge Aclk);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            chk($sformatf("reset_result%0d", i), rd_data, 0);
        end

        // Table pass: every vector, sequence checked on two of them,
        // all-ones vector run back-to-back.
        for (int vi = 0; vi < 5; vi++) begin
            load(vi);
            push_exp(vi);
            run($sformatf("vec%0d", vi), 16, (vi == 0 || vi == 4), 1'b0, 1'b0, 1'b0);
            if (vi == 1) begin
                push_exp(vi);
                run("vec1_b2b", 16, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end

        // Out-of-range writes must not alias onto valid words.
        load(3);
        write_word(1'b0, 4'd9, 8'h55);
        write_word(1'b1, 4'd4, 8'h33);
        write_word(1'b1, 4'd7, 8'h44);
        push_exp(3);
        run("oor_writes", 16, 1'b1, 1'b0, 1'b0, 1'b0);

        // Writes and start during busy are ignored.
        push_exp(3);
        run("busy_writes", 16, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp(3);
        run("after_busy_writes", 16, 1'b0, 1'b0, 1'b0, 1'b0);

        // result_done never arrives: timeout, result file untouched.
        tie_low = 1'b1;
        push_exp(3);
        run("timeout", TIMEOUT_DEF + 10, 1'b0, 1'b0, 1'b0, 1'b1);
        tie_low = 1'b0;
        chk("timeout_err_sticky", err, 1);

        // result_done drops during capture: first two results land, rest keep
        // the previous run's values.
        load(0);
        drop_mode = 1'b1;
        exp_q.push_back(16'd6);
        exp_q.push_back(16'd8);
        exp_q.push_back(16'd16);
        exp_q.push_back(16'd12);
        run("drop", 15, 1'b0, 1'b0, 1'b0, 1'b1);
        drop_mode = 1'b0;

        // Reset at S+5 aborts and clears everything.
        load(1);
        run("abort", 0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge Aclk);
        chk("abort_busy_after", busy, 0);
        for (int i = 0; i < 9; i++) cur_p[i] = '0;
        for (int i = 0; i < 4; i++) cur_k[i] = '0;
        for (int i = 0; i < 4; i++) exp_q.push_back('0);
        run("cleared_files", 16, 1'b1, 1'b0, 1'b0, 1'b0);
        load(2);
        push_exp(2);
        run("after_abort", 16, 1'b0, 1'b0, 1'b0, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=hung required=finish");
        $fatal(1, "bench time limit");
    end

endmodule
